// File: rtl/usrt_tx_framer.sv
// usrt_tx_framer: byte FIFO feeding an 11-bit frame serializer (start, 8 data LSB-first, parity, stop).
// Define USRT_TX_ODD_PARITY_EN to send odd parity; the default build sends even parity.
module usrt_tx_framer #(
    parameter int DEPTH = 4,
    parameter int LVL_W = 3
) (
    input  logic             pClk,
    input  logic             pReset,
    input  logic             uClk,
    input  logic [7:0]       wData,
    input  logic             wValid,
    output logic             wReady,
    output logic             Rx,
    output logic             busy,
    output logic [LVL_W-1:0] level
);
    localparam int PTR_W = LVL_W - 1;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic [0:0]       state_q, state_d;
    logic [3:0]       bitcnt_q, bitcnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             par_q, par_d;
    logic             rx_q, rx_d;
    logic             push, pop;

    function automatic logic parity_bit(input logic [7:0] d);
`ifdef USRT_TX_ODD_PARITY_EN
        return ~(^d);
`else
        return ^d;
`endif
    endfunction

    assign wReady = (count_q != LVL_W'(DEPTH));
    assign level  = count_q;
    assign busy   = (state_q == ST_SEND) || (count_q != '0);
    assign Rx     = rx_q;

    // A frame may only start on a tick when idle or after the stop bit has had its full period.
    assign push = wValid && wReady && !pReset;
    assign pop  = uClk && (count_q != '0) &&
                  ((state_q == ST_IDLE) || (bitcnt_q == 4'd11));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        par_d    = par_q;
        rx_d     = rx_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + LVL_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - LVL_W'(1);
        end

        if (pop) begin
            shreg_d  = mem_q[rd_ptr_q];
            par_d    = parity_bit(mem_q[rd_ptr_q]);
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            rx_d     = 1'b1;
            bitcnt_d = 4'd1;
            state_d  = ST_SEND;
        end else if (uClk && (state_q == ST_SEND)) begin
            if (bitcnt_q <= 4'd8) begin
                rx_d     = shreg_q[0];
                shreg_d  = {1'b0, shreg_q[7:1]};
                bitcnt_d = bitcnt_q + 4'd1;
            end else if (bitcnt_q == 4'd9) begin
                rx_d     = par_q;
                bitcnt_d = bitcnt_q + 4'd1;
            end else if (bitcnt_q == 4'd10) begin
                rx_d     = 1'b0;
                bitcnt_d = bitcnt_q + 4'd1;
            end else begin
                rx_d     = 1'b0;
                bitcnt_d = 4'd0;
                state_d  = ST_IDLE;
            end
        end
    end

    always_ff @(posedge pClk) begin
        if (pReset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= ST_IDLE;
            bitcnt_q <= 4'd0;
            rx_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            rx_q     <= rx_d;
        end
    end

    // Data-path registers carry no reset; they are always reloaded by a pop before use.
    always_ff @(posedge pClk) begin
        shreg_q <= shreg_d;
        par_q   <= par_d;
        if (push) begin
            mem_q[wr_ptr_q] <= wData;
        end
    end
endmodule

// File: tb/tb_usrt_tx_framer.sv
// Bench for usrt_tx_framer: scoreboard of expected line bits per tick period plus directed corner cases.
module tb_usrt_tx_framer;
    localparam int GAP = 80;
`ifdef USRT_TX_ODD_PARITY_EN
    localparam logic ODD = 1'b1;
`else
    localparam logic ODD = 1'b0;
`endif

    logic       pClk = 1'b0;
    logic       pReset, uClk, wValid, wReady, Rx, busy;
    logic [7:0] wData;
    logic [2:0] level;

    int n_checks = 0;
    int n_fail   = 0;
    logic expq[$];

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;
    vec_t vecs[6];

    usrt_tx_framer #(.DEPTH(4), .LVL_W(3)) dut (
        .pClk(pClk), .pReset(pReset), .uClk(uClk), .wData(wData), .wValid(wValid),
        .wReady(wReady), .Rx(Rx), .busy(busy), .level(level)
    );

    always #5 pClk = ~pClk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_par(input logic [7:0] d);
        logic p = 1'b0;
        for (int i = 0; i < 8; i++) p = p ^ d[i];
        return p ^ ODD;
    endfunction

    task automatic queue_frame(input logic [7:0] d, input logic par);
        expq.push_back(1'b1);
        for (int i = 0; i < 8; i++) expq.push_back(d[i]);
        expq.push_back(par);
        expq.push_back(1'b0);
    endtask

    task automatic push_byte(input logic [7:0] d, input logic par);
        check("wready_before_push", wReady, 1);
        wValid = 1'b1;
        wData  = d;
        @(negedge pClk);
        wValid = 1'b0;
        queue_frame(d, par);
    endtask

    task automatic tick(input int gap);
        logic exp_bit;
        uClk = 1'b1;
        @(negedge pClk);
        uClk = 1'b0;
        exp_bit = (expq.size() > 0) ? expq.pop_front() : 1'b0;
        check("rx_bit", Rx, exp_bit);
        repeat (gap - 2) @(negedge pClk);
        check("rx_hold", Rx, exp_bit);
        @(negedge pClk);
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && expq.size() > 0; k++) tick(GAP);
        check("drain_empty", expq.size(), 0);
        tick(GAP);
        check("busy_after_drain", busy, 0);
        check("level_after_drain", level, 0);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b0 ^ ODD};
        vecs[1] = '{8'h00, 1'b0 ^ ODD};
        vecs[2] = '{8'hFF, 1'b0 ^ ODD};
        vecs[3] = '{8'h7F, 1'b1 ^ ODD};
        vecs[4] = '{8'h01, 1'b1 ^ ODD};
        vecs[5] = '{8'h80, 1'b1 ^ ODD};

        pReset = 1'b1;
        uClk   = 1'b0;
        wValid = 1'b0;
        wData  = 8'h00;
        repeat (3) @(negedge pClk);
        pReset = 1'b0;
        check("reset_rx", Rx, 0);
        check("reset_busy", busy, 0);
        check("reset_level", level, 0);
        check("reset_wready", wReady, 1);

        // Single frames from the table, one at a time.
        for (int v = 0; v < 6; v++) begin
            push_byte(vecs[v].data, vecs[v].par);
            check("level_after_push", level, 1);
            check("busy_after_push", busy, 1);
            repeat (11) tick(GAP);
            check("busy_in_stop", busy, 1);
            check("level_in_frame", level, 0);
            tick(GAP);
            check("busy_after_frame", busy, 0);
            check("level_after_frame", level, 0);
            check("rx_idle", Rx, 0);
        end

        // Back-to-back frames with no idle gap.
        push_byte(8'h01, model_par(8'h01));
        push_byte(8'h80, model_par(8'h80));
        check("level_two", level, 2);
        drain();

        // Fill to full with ticks held off; extra bytes must stall.
        for (int i = 0; i < 6; i++) begin
            wValid = 1'b1;
            wData  = 8'h10 + 8'(i);
            check("wready_fill", wReady, (i < 4) ? 1 : 0);
            @(negedge pClk);
            if (i < 4) queue_frame(8'h10 + 8'(i), model_par(8'h10 + 8'(i)));
        end
        wValid = 1'b0;
        check("level_full", level, 4);
        check("wready_full", wReady, 0);
        tick(GAP);
        check("level_after_pop", level, 3);
        check("wready_after_pop", wReady, 1);
        push_byte(8'h14, model_par(8'h14));
        check("level_refull", level, 4);
        repeat (11) tick(GAP);
        check("level_second_pop", level, 3);
        push_byte(8'h15, model_par(8'h15));
        drain();

        // Push into an empty FIFO on the same cycle as a tick: no start on that tick.
        uClk   = 1'b1;
        wValid = 1'b1;
        wData  = 8'h3C;
        @(negedge pClk);
        uClk   = 1'b0;
        wValid = 1'b0;
        check("same_cycle_no_start", Rx, 0);
        check("same_cycle_level", level, 1);
        repeat (GAP - 1) @(negedge pClk);
        check("same_cycle_still_idle", Rx, 0);
        queue_frame(8'h3C, model_par(8'h3C));
        drain();

        // Reset during data bit 5 with two bytes queued; wValid is ignored during reset.
        push_byte(8'h55, model_par(8'h55));
        push_byte(8'h66, model_par(8'h66));
        push_byte(8'h77, model_par(8'h77));
        repeat (6) tick(GAP);
        check("level_before_reset", level, 2);
        pReset = 1'b1;
        wValid = 1'b1;
        wData  = 8'hEE;
        @(negedge pClk);
        pReset = 1'b0;
        wValid = 1'b0;
        check("midreset_rx", Rx, 0);
        check("midreset_level", level, 0);
        check("midreset_busy", busy, 0);
        check("midreset_wready", wReady, 1);
        expq.delete();
        repeat (13) tick(GAP);
        check("post_reset_level", level, 0);
        check("post_reset_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/usrt_tx_framer.md
Name: usrt_tx_framer

Overview:
Transmit-side stage between the APB write path and the USRT line. It accepts bytes from the bus-side data register through a valid/ready handshake and buffers them in a small FIFO. It frames each byte as 11 bits (start, 8 data LSB-first, parity, stop) and shifts the frame out on Rx, one bit per baud tick from baud_gen. Everything runs in the pClk domain; uClk is used only as a single-cycle enable.

Parameters:
DEPTH, 4, FIFO depth in bytes; power of two, >= 2
LVL_W, 3, width of level output; must equal log2(DEPTH)+1

Ports:
pClk  input  1  system clock; all logic on rising edge
pReset  input  1  synchronous reset, active-high
uClk  input  1  baud tick from baud_gen; one pClk cycle wide; treated as an enable, never as a clock
wData  input  8  byte to transmit
wValid  input  1  wData valid
wReady  output  1  FIFO can accept a byte (= !full)
Rx  output  1  serial line out
busy  output  1  frame in progress or FIFO non-empty
level  output  LVL_W  current FIFO occupancy, 0..DEPTH

Behaviour:
- Reset (pReset=1 at a pClk edge): FIFO pointers and count cleared, state IDLE, bit counter 0, Rx=0, busy=0, level=0, wReady=1 from the next cycle. Applies mid-frame: the frame in progress is abandoned and Rx returns to 0 on the next cycle. wValid is ignored while pReset=1.
- Line polarity: idle=0, start bit=1, stop bit=0.
- Parity bit: XOR of the 8 data bits (even parity).
- Push: on a cycle with wValid && wReady, write wData at the write pointer; the pointer wraps modulo DEPTH. No push occurs when full; the stalled byte is held by the producer.
- Pop: happens only on a uClk cycle in which a frame is started. It reads the head into the shift register; the read pointer wraps modulo DEPTH.
- Count update: count <= count + push - pop. Push and pop in the same cycle leave count unchanged.
- Empty test for a pop uses registered count. A byte pushed in the same cycle as a tick into an empty FIFO is not popped until a later tick.
- State IDLE:
  - Rx=0.
  - On uClk with count>0: pop, Rx<=1 (start bit), bitcnt<=1, go to SEND.
  - On uClk with count=0: no change.
- State SEND: acts only on uClk cycles; otherwise holds Rx and bitcnt.
  - bitcnt 1..8: Rx<=data[bitcnt-1], bitcnt+1.
  - bitcnt 9: Rx<=parity, bitcnt+1.
  - bitcnt 10: Rx<=0 (stop bit), bitcnt+1.
  - bitcnt 11, count>0: pop, Rx<=1, bitcnt<=1. Back-to-back frames have no idle gap.
  - bitcnt 11, count=0: Rx<=0, bitcnt<=0, go to IDLE.
- Each bit is held for exactly one tick period. The first bit appears one pClk after the tick that starts it.
- busy = (state==SEND) || (count!=0), registered-equivalent; it goes low the cycle after the return to IDLE.
- wReady = (count!=DEPTH). level = count.

Optional Feature:
- Macro: USRT_TX_ODD_PARITY_EN.
- Defined: parity bit = ~(XOR of data), i.e. odd parity.
- Undefined: even parity as specified above.
- All other behaviour is identical.

Test Plan:
- Reset, push 0xA5, then a tick every 80 pClk -> Rx over successive tick periods = 1, then 1,0,1,0,0,1,0,1, then parity 0, then stop 0, then idle 0. busy falls after the 11th bit period; level returns to 0.
- Push 0x01 and 0x80 back-to-back -> two contiguous frames, the second start bit immediately after the first stop bit. Second frame data = 0,0,0,0,0,0,0,1; parity 1.
- Hold uClk=0, assert wValid for 6 cycles with 0x10..0x15 -> wReady drops after 4 pushes, level=4. Then ticks -> frames carry 0x10,0x11,0x12,0x13 in order, and 0x14 is accepted after the first pop.
- Push into an empty FIFO in the same cycle as a tick -> no start on that tick; start bit appears after the next tick.
- Assert pReset during bit 5 of a frame with 2 bytes queued -> Rx=0, level=0, busy=0 next cycle; no further frames without new pushes.
- With USRT_TX_ODD_PARITY_EN, send 0xA5 -> parity bit 1; send 0x00 -> parity bit 1.
